// File: rtl/gen_scheduler_pkg.sv
// Shared definitions for the Game of Life generation scheduler:
// FSM state encodings, speed-to-period mapping and the default debounce length.
package gen_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_GEN  = 2'd2,
    ST_LOAD = 2'd3
  } state_e;

  localparam int PERIOD_SPD0      = 60;
  localparam int PERIOD_SPD1      = 15;
  localparam int PERIOD_SPD2      = 4;
  localparam int PERIOD_SPD3      = 1;
  localparam int DEBOUNCE_DEFAULT = 250000;

  // Frame counter compare value (period - 1) for a given speed code.
  function automatic logic [5:0] period_m1(input logic [1:0] spd);
    case (spd)
      2'b00:   return 6'(PERIOD_SPD0 - 1);
      2'b01:   return 6'(PERIOD_SPD1 - 1);
      2'b10:   return 6'(PERIOD_SPD2 - 1);
      default: return 6'(PERIOD_SPD3 - 1);
    endcase
  endfunction

endpackage

// File: rtl/gen_scheduler_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, plus a stability filter when
// GOL_BTN_DEBOUNCE_EN is defined. Outputs a clean level only.
module btn_debounce
  import gen_scheduler_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level
);

  logic sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

`ifdef GOL_BTN_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            level_q, level_d;

  // Any cycle where the input agrees with the accepted level restarts the count.
  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt_q <= '0;
      level_q  <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
    end
  end

  assign level = level_q;
`else
  // Synchroniser only; the debounce length has no effect in this build.
  if (DEBOUNCE_CYCLES >= 0) begin : g_sync_only
    assign level = sync2_q;
  end
`endif

endmodule

// File: rtl/gen_scheduler.sv
// Frame-synchronous generation/load request scheduler for the Conway datapath.
// Button filtering depends on GOL_BTN_DEBOUNCE_EN (see btn_debounce).
module gen_scheduler
  import gen_scheduler_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step_btn,
  input  logic             load_btn,
  input  logic [1:0]       speed,
  input  logic             vsync,
  output logic             gen_req,
  output logic             load_req,
  input  logic             ack,
  output logic             busy,
  output logic [CNT_W-1:0] gen_count
);

  logic             step_lvl, load_lvl;
  logic             vsync_q, step_prev_q, load_prev_q;
  logic             frame_edge, step_rise, load_rise, gen_hit;
  logic [5:0]       frame_cnt_q, frame_cnt_d;
  logic             gen_pend_q, gen_pend_d;
  logic             step_pend_q, step_pend_d;
  logic             load_pend_q, load_pend_d;
  state_e           state_q;
  logic             gen_req_q, load_req_q;
  logic [CNT_W-1:0] gen_count_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk(clk), .rst(rst), .btn(step_btn), .level(step_lvl)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
    .clk(clk), .rst(rst), .btn(load_btn), .level(load_lvl)
  );

  assign frame_edge = vsync_q & ~vsync;
  assign step_rise  = step_lvl & ~step_prev_q;
  assign load_rise  = load_lvl & ~load_prev_q;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    gen_hit     = 1'b0;
    if (!run) begin
      frame_cnt_d = '0;
    end else if (frame_edge) begin
      if (frame_cnt_q >= period_m1(speed)) begin
        gen_hit     = 1'b1;
        frame_cnt_d = '0;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Completion clears first so that a request arriving in the same cycle survives.
  always_comb begin
    gen_pend_d  = gen_pend_q;
    step_pend_d = step_pend_q;
    load_pend_d = load_pend_q;
    if (ack && (state_q == ST_GEN || state_q == ST_LOAD)) begin
      gen_pend_d  = 1'b0;
      step_pend_d = 1'b0;
    end
    if (ack && state_q == ST_LOAD) load_pend_d = 1'b0;
    if (run) step_pend_d = 1'b0;
    if (gen_hit) gen_pend_d = 1'b1;
    if (step_rise && !run) step_pend_d = 1'b1;
    if (load_rise) load_pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q     <= 1'b0;
      step_prev_q <= 1'b0;
      load_prev_q <= 1'b0;
      frame_cnt_q <= '0;
      gen_pend_q  <= 1'b0;
      step_pend_q <= 1'b0;
      load_pend_q <= 1'b0;
    end else begin
      vsync_q     <= vsync;
      step_prev_q <= step_lvl;
      load_prev_q <= load_lvl;
      frame_cnt_q <= frame_cnt_d;
      gen_pend_q  <= gen_pend_d;
      step_pend_q <= step_pend_d;
      load_pend_q <= load_pend_d;
    end
  end

  // IDLE also services on a frame edge so a free-run hit is issued on the very frame it lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gen_req_q   <= 1'b0;
      load_req_q  <= 1'b0;
      gen_count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ARM: begin
          if (frame_edge && load_pend_d) begin
            state_q    <= ST_LOAD;
            load_req_q <= 1'b1;
          end else if (frame_edge && (gen_pend_d || step_pend_d)) begin
            state_q   <= ST_GEN;
            gen_req_q <= 1'b1;
          end else if (gen_pend_d || step_pend_d || load_pend_d) begin
            state_q <= ST_ARM;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_GEN: begin
          if (ack) begin
            state_q     <= ST_IDLE;
            gen_req_q   <= 1'b0;
            gen_count_q <= gen_count_q + 1'b1;
          end
        end
        ST_LOAD: begin
          if (ack) begin
            state_q     <= ST_IDLE;
            load_req_q  <= 1'b0;
            gen_count_q <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gen_req   = gen_req_q;
  assign load_req  = load_req_q;
  assign busy      = (state_q != ST_IDLE);
  assign gen_count = gen_count_q;

endmodule

// File: tb/tb_gen_scheduler.sv
// Directed bench for gen_scheduler: free-run, single-step, load priority,
// slow ack, reset mid-handshake, speed change and counter wrap.
module tb_gen_scheduler;

  logic       clk = 1'b0;
  logic       rst, run, step_btn, load_btn, vsync, ack;
  logic [1:0] speed;
  logic       gen_req, load_req, busy;
  logic [7:0] gen_count;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   gen_pulses = 0;
  int   load_pulses = 0;
  logic auto_ack = 1'b1;
  logic force_ack = 1'b0;

  gen_scheduler #(.DEBOUNCE_CYCLES(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .run(run), .step_btn(step_btn), .load_btn(load_btn),
    .speed(speed), .vsync(vsync), .gen_req(gen_req), .load_req(load_req),
    .ack(ack), .busy(busy), .gen_count(gen_count)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  // Conway model: acks 3 cycles after a request rises, counts request pulses.
  initial begin
    logic gen_prev, load_prev;
    int   req_age;
    ack = 1'b0; gen_prev = 1'b0; load_prev = 1'b0; req_age = 0;
    forever begin
      @(posedge clk); #2;
      if (gen_req && !gen_prev) gen_pulses++;
      if (load_req && !load_prev) load_pulses++;
      gen_prev = gen_req;
      load_prev = load_req;
      if ((gen_req || load_req) && auto_ack) req_age++;
      else req_age = 0;
      ack = force_ack || (req_age == 3);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; auto_ack = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic frame(input int len, output logic req_g, output logic req_l);
    vsync = 1'b0;
    tick(1);
    req_g = gen_req;
    req_l = load_req;
    tick(2);
    vsync = 1'b1;
    tick(len - 3);
  endtask

  task automatic press_step();
    step_btn = 1'b1; tick(14);
    step_btn = 1'b0; tick(14);
  endtask

  task automatic press_load();
    load_btn = 1'b1; tick(14);
    load_btn = 1'b0; tick(14);
  endtask

  task automatic pulse_ack();
    force_ack = 1'b1;
    tick(1);
    force_ack = 1'b0;
  endtask

  initial begin
    logic g, l;
    int   base_g, base_l;
    rst = 1'b1; run = 1'b0; step_btn = 1'b0; load_btn = 1'b0;
    speed = 2'b00; vsync = 1'b1;
    tick(3);
    check("rst_gen_req", gen_req, 0);
    check("rst_load_req", load_req, 0);
    check("rst_busy", busy, 0);
    check("rst_gen_count", gen_count, 0);
    rst = 1'b0;
    tick(1);

    // Free-run, 4 frames per generation
    do_reset();
    run = 1'b1; speed = 2'b10; base_g = gen_pulses;
    for (int i = 0; i < 12; i++) begin
      frame(10, g, l);
      check($sformatf("free_req_fall%0d", i + 1), g, 32'((i % 4) == 3));
    end
    check("free_pulses", gen_pulses - base_g, 3);
    check("free_count", gen_count, 3);

    // Single-step, presses collapse
    do_reset();
    run = 1'b0;
    press_step(); press_step(); press_step();
    check("step_armed_busy", busy, 1);
    check("step_no_early_req", gen_req, 0);
    base_g = gen_pulses;
    frame(10, g, l);
    check("step_req", g, 1);
    check("step_count1", gen_count, 1);
    frame(10, g, l);
    check("step_no_req_unpressed", g, 0);
    press_step();
    frame(10, g, l);
    check("step_req2", g, 1);
    check("step_count2", gen_count, 2);
    check("step_pulses", gen_pulses - base_g, 2);

    // Load priority over pending step
    do_reset();
    press_step();
    frame(10, g, l);
    check("load_pre_count", gen_count, 1);
    base_g = gen_pulses; base_l = load_pulses;
    press_step(); press_load();
    frame(10, g, l);
    check("load_req", l, 1);
    check("load_no_gen", g, 0);
    check("load_count_cleared", gen_count, 0);
    frame(10, g, l);
    check("load_stale_step_gen", g, 0);
    check("load_stale_step_load", l, 0);
    check("load_gen_pulses", gen_pulses - base_g, 0);
    check("load_pulses", load_pulses - base_l, 1);

    // Speed change with the frame counter at 30, then wrap
    do_reset();
    run = 1'b1; speed = 2'b00; base_g = gen_pulses;
    for (int i = 0; i < 30; i++) frame(10, g, l);
    check("speed0_no_pulses", gen_pulses - base_g, 0);
    speed = 2'b11;
    frame(10, g, l);
    check("speed_change_req", g, 1);
    check("speed_change_count", gen_count, 1);
    for (int i = 0; i < 254; i++) frame(8, g, l);
    check("wrap_pre_count", gen_count, 8'hFF);
    frame(8, g, l);
    check("wrap_req", g, 1);
    check("wrap_count", gen_count, 8'h00);

    // Slow ack across two frame edges
    do_reset();
    run = 1'b1; speed = 2'b11; auto_ack = 1'b0;
    frame(10, g, l);
    check("slow_req_f1", g, 1);
    frame(10, g, l);
    check("slow_req_f2", g, 1);
    check("slow_busy", busy, 1);
    frame(10, g, l);
    check("slow_req_f3", g, 1);
    pulse_ack();
    check("slow_req_dropped", gen_req, 0);
    check("slow_count", gen_count, 1);
    check("slow_idle", busy, 0);
    tick(3);
    check("slow_no_early_req", gen_req, 0);
    frame(10, g, l);
    check("slow_next_req", g, 1);

    // Reset mid-handshake, late ack ignored
    rst = 1'b1;
    tick(1);
    check("midrst_gen_req", gen_req, 0);
    check("midrst_load_req", load_req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_count", gen_count, 0);
    rst = 1'b0;
    tick(1);
    pulse_ack();
    tick(2);
    check("late_ack_count", gen_count, 0);
    check("late_ack_busy", busy, 0);
    check("late_ack_gen_req", gen_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
